hyper_arb_rr_nch: RTL and testbench

- Parametrised N-channel round-robin arbiter; successor to the fixed 2-input RR primitive in the uDMA HyperBus datapath.
- Merges NUM_CH req/gnt request streams (data + id) onto one downstream req/gnt port through a one-entry registered output slice.
- Adds a rotating priority pointer held in state, optional burst lock (channel holds ownership until its last beat), and a channel-index output so responses can be routed back.

---
 rtl/hyper_arb_pkg.sv | 17 +
 rtl/hyper_arb_rr_pick.sv | 36 +++
 rtl/hyper_arb_rr_nch.sv | 114 +++++++++++
 tb/tb_hyper_arb_rr_nch.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/hyper_arb_pkg.sv
// Shared types and helpers for the uDMA HyperBus round-robin arbiters.
package hyper_arb_pkg;

  // Wide enough for any channel count these arbiters are built with (<= 256).
  localparam int RR_IDX_W = 8;

  typedef struct packed {
    logic [RR_IDX_W-1:0] ptr;
    logic                lock;
    logic [RR_IDX_W-1:0] lock_ch;
  } rr_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hyper_arb_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module hyper_arb_rr_pick
  import hyper_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0]   req,
  input  logic [RR_IDX_W-1:0] ptr,
  output logic [NUM_CH-1:0]   win_oh,
  output logic [CH_W-1:0]     win_idx,
  output logic                win_vld
);

  logic [NUM_CH-1:0]   mask;
  logic [2*NUM_CH-1:0] dbl;
  logic                found;

  // Lower half holds requests at or above ptr, upper half the full vector,
  // so the lowest set bit of the pair is the wrapped round-robin winner.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) mask[c] = (c >= int'(ptr));
    dbl     = {req, req & mask};
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < 2*NUM_CH; i++) begin
      if (!found && dbl[i]) begin
        found   = 1'b1;
        win_idx = CH_W'(i % NUM_CH);
      end
    end
    for (int c = 0; c < NUM_CH; c++) win_oh[c] = found && (win_idx == CH_W'(c));
    win_vld = found;
  end

endmodule

// File: rtl/hyper_arb_rr_nch.sv
// N-channel round-robin arbiter with optional burst lock and a one-entry output slice.
module hyper_arb_rr_nch
  import hyper_arb_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int ID_WIDTH   = 4,
  parameter  int LOCK_EN    = 1,
  localparam int CH_W       = clog2_min1(NUM_CH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            req_i,
  output logic [NUM_CH-1:0]            gnt_o,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_CH*ID_WIDTH-1:0]   id_i,
  input  logic [NUM_CH-1:0]            last_i,
  output logic                         req_o,
  input  logic                         gnt_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic [ID_WIDTH-1:0]          id_o,
  output logic [CH_W-1:0]              ch_o,
  output logic                         last_o
);

  rr_state_t st_q, st_d;

  logic                  space, xfer, locked;
  logic                  pick_vld, win_vld, win_last;
  logic [NUM_CH-1:0]     pick_oh, lock_sel, win_oh;
  logic [CH_W-1:0]       pick_idx, lock_idx, win_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic [ID_WIDTH-1:0]   win_id;

  assign locked = (LOCK_EN != 0) && st_q.lock;
  assign space  = ~req_o | gnt_i;

  hyper_arb_rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
    .req     (req_i),
    .ptr     (st_q.ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  // While locked only the owning channel may win; everyone else stalls.
  always_comb begin
    lock_idx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      lock_sel[c] = req_i[c] && (st_q.lock_ch == RR_IDX_W'(c));
      if (st_q.lock_ch == RR_IDX_W'(c)) lock_idx = CH_W'(c);
    end
    if (locked) begin
      win_oh  = lock_sel;
      win_idx = lock_idx;
      win_vld = |lock_sel;
    end else begin
      win_oh  = pick_oh;
      win_idx = pick_idx;
      win_vld = pick_vld;
    end
  end

  always_comb begin
    win_data = '0;
    win_id   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (win_oh[c]) begin
        win_data = data_i[c*DATA_WIDTH +: DATA_WIDTH];
        win_id   = id_i[c*ID_WIDTH +: ID_WIDTH];
      end
    end
    win_last = |(last_i & win_oh);
  end

  assign xfer  = win_vld & space;
  assign gnt_o = xfer ? win_oh : '0;

  // Pointer only moves past a channel once its burst has finished.
  always_comb begin
    st_d = st_q;
    if (xfer) begin
      if (LOCK_EN == 0 || win_last)
        st_d.ptr = RR_IDX_W'((int'(win_idx) + 1) % NUM_CH);
      if (LOCK_EN != 0) begin
        st_d.lock = ~win_last;
        if (!win_last) st_d.lock_ch = RR_IDX_W'(win_idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= '0;
      req_o  <= 1'b0;
      data_o <= '0;
      id_o   <= '0;
      ch_o   <= '0;
      last_o <= 1'b0;
    end else begin
      st_q <= st_d;
      if (xfer) begin
        req_o  <= 1'b1;
        data_o <= win_data;
        id_o   <= win_id;
        ch_o   <= win_idx;
        last_o <= win_last;
      end else if (gnt_i) begin
        req_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hyper_arb_rr_nch.sv
// Bench for hyper_arb_rr_nch: directed table, corner sequences, then random vs. a reference model.
module tb_hyper_arb_rr_nch;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_i, gnt_o, last_i;
  logic [N*DW-1:0] data_i;
  logic [N*IW-1:0] id_i;
  logic            req_o, gnt_i, last_o;
  logic [DW-1:0]   data_o;
  logic [IW-1:0]   id_o;
  logic [1:0]      ch_o;

  always #5 clk = ~clk;

  hyper_arb_rr_nch #(.NUM_CH(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LOCK_EN(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .data_i(data_i),
    .id_i(id_i), .last_i(last_i), .req_o(req_o), .gnt_i(gnt_i), .data_o(data_o),
    .id_o(id_o), .ch_o(ch_o), .last_o(last_o)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model: arbitration rules applied directly on integers.
  int            m_ptr, m_lock, m_lock_ch, m_vld, m_ch;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_id;
  logic          m_last;
  int            seq [N];

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic         gi;
    logic [N-1:0] exp_gnt;
    logic         exp_ro;
    logic [1:0]   exp_ch;
  } vec_t;
  vec_t vec [10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int model_win(input logic [N-1:0] r);
    if (m_lock != 0) return r[m_lock_ch] ? m_lock_ch : -1;
    for (int k = 0; k < N; k++) if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_lock = 0; m_lock_ch = 0; m_vld = 0; m_ch = 0;
    m_data = '0; m_id = '0; m_last = 1'b0;
  endtask

  // One clock: drive, check at negedge, advance the model at posedge.
  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic g, input logic rs,
                     output logic [N-1:0] g_act, output logic ro_act, output logic [1:0] ch_act);
    int w;
    logic sp;
    logic [N-1:0] eg;
    rst_i = rs; req_i = r; last_i = l; gnt_i = g;
    for (int c = 0; c < N; c++) begin
      data_i[c*DW +: DW] = {8'(c), 24'(seq[c])};
      id_i[c*IW +: IW]   = IW'(seq[c] * 3 + c);
    end
    @(negedge clk);
    w  = model_win(r);
    sp = (m_vld == 0) || g;
    eg = (w >= 0 && sp) ? N'(1 << w) : '0;
    if (!rs) check("gnt_o", gnt_o, eg);
    check("req_o", req_o, m_vld[0]);
    check("data_o", data_o, m_data);
    check("id_o", id_o, m_id);
    check("ch_o", ch_o, m_ch);
    check("last_o", last_o, m_last);
    g_act = gnt_o; ro_act = req_o; ch_act = ch_o;
    @(posedge clk);
    if (rs) model_reset();
    else if (w >= 0 && sp) begin
      m_vld = 1; m_ch = w; m_last = l[w];
      m_data = data_i[w*DW +: DW];
      m_id   = id_i[w*IW +: IW];
      if (l[w]) begin m_ptr = (w + 1) % N; m_lock = 0; end
      else begin m_lock = 1; m_lock_ch = w; end
      seq[w]++;
    end else if (g) m_vld = 0;
    #1;
  endtask

  initial begin
    logic [N-1:0]  ga;
    logic          ra;
    logic [1:0]    ca;
    logic [DW-1:0] held, nxt;

    vec[0] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    vec[1] = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    vec[2] = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    vec[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    vec[4] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
    vec[5] = '{4'b1010, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    vec[6] = '{4'b1010, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1};
    vec[7] = '{4'b1010, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd3};
    vec[8] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1};
    vec[9] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};

    for (int c = 0; c < N; c++) seq[c] = 0;
    model_reset();
    rst_i = 1'b1; req_i = '0; last_i = '0; gnt_i = 1'b0; data_i = '0; id_i = '0;
    repeat (2) @(posedge clk);
    #1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      cyc('0, '0, 1'b0, 1'b0, ga, ra, ca);
      check("idle_gnt", ga, 4'b0000);
      check("idle_req_o", ra, 1'b0);
      check("idle_ch", ca, 2'd0);
    end

    // Fairness rotation, then skipping idle channels
    for (int i = 0; i < 10; i++) begin
      cyc(vec[i].req, vec[i].last, vec[i].gi, 1'b0, ga, ra, ca);
      check($sformatf("vec%0d_gnt", i), ga, vec[i].exp_gnt);
      check($sformatf("vec%0d_req_o", i), ra, vec[i].exp_ro);
      check($sformatf("vec%0d_ch", i), ca, vec[i].exp_ch);
    end

    // Burst lock: ch2 keeps four beats while ch0/ch1 wait, then ch3 is skipped
    for (int b = 1; b <= 4; b++) begin
      cyc(4'b0111, (b == 4) ? 4'b0111 : 4'b0011, 1'b1, 1'b0, ga, ra, ca);
      check("lock_gnt", ga, 4'b0100);
      if (b >= 2) check("lock_ch", ca, 2'd2);
    end
    cyc(4'b0111, 4'b0011, 1'b1, 1'b0, ga, ra, ca);
    check("unlock_gnt", ga, 4'b0001);
    check("unlock_ch", ca, 2'd2);

    // Backpressure: one beat captured, then a same-cycle drain and reload
    cyc('0, '0, 1'b1, 1'b0, ga, ra, ca);
    cyc(4'b0010, 4'b0010, 1'b0, 1'b0, ga, ra, ca);
    check("bp_first_gnt", ga, 4'b0010);
    held = data_i[1*DW +: DW];
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0010, 4'b0010, 1'b0, 1'b0, ga, ra, ca);
      check("bp_stall_gnt", ga, 4'b0000);
      check("bp_req_o", ra, 1'b1);
      check("bp_data_hold", data_o, held);
    end
    cyc(4'b0010, 4'b0010, 1'b1, 1'b0, ga, ra, ca);
    check("bp_release_gnt", ga, 4'b0010);
    nxt = data_i[1*DW +: DW];
    cyc('0, '0, 1'b1, 1'b0, ga, ra, ca);
    check("bp_reload_req_o", ra, 1'b1);
    check("bp_reload_data", data_o, nxt);

    // Reset in the middle of a locked ch2 burst
    cyc(4'b0100, 4'b0000, 1'b1, 1'b0, ga, ra, ca);
    check("rb_beat1", ga, 4'b0100);
    cyc(4'b0100, 4'b0000, 1'b1, 1'b0, ga, ra, ca);
    check("rb_beat2", ga, 4'b0100);
    cyc(4'b0100, 4'b0000, 1'b1, 1'b1, ga, ra, ca);
    cyc(4'b0101, 4'b0101, 1'b1, 1'b0, ga, ra, ca);
    check("rb_req_o_clear", ra, 1'b0);
    check("rb_ch0_first", ga, 4'b0001);
    cyc(4'b0100, 4'b0100, 1'b1, 1'b0, ga, ra, ca);
    check("rb_ch2_next", ga, 4'b0100);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)),
          $urandom_range(0, 3) != 0, 1'b0, ga, ra, ca);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
